// File: rtl/mm_pkg.sv
// Shared types and size helpers for the matrix-multiplier stream host.
// Optional watchdog is enabled by defining MM_WATCHDOG_EN.
package mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_KICK,
    S_WAIT,
    S_DRAIN
  } state_e;

  function automatic int vec_size(int l);
    return 1 << l;
  endfunction

  function automatic int mat_size(int l);
    return 1 << (2 * l);
  endfunction

  function automatic int addr_w(int l);
    return 2 * l + 1;
  endfunction

endpackage

// File: rtl/mm_stream_host_if.sv
// Stream and multiplier-port bundles for mm_stream_host.
// Stream slaves ignore tlast; only the result stream drives it.
interface mm_axis_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid,
    output tready
  );
endinterface

interface mm_core_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          start;
  logic          done;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rddata;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic          we;

  modport host (
    output start, rddata,
    input  done, rdaddr, wraddr, wrdata, we
  );

  modport core (
    input  start, rddata,
    output done, rdaddr, wraddr, wrdata, we
  );
endinterface

// File: rtl/mm_op_ram.sv
// Operand/result RAM: one synchronous write port, two async reads.
// Contents are deliberately not reset.
module mm_op_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mm_stream_host.sv
// Host side of the matrix multiplier: fill RAM, kick, serve, drain.
// Define MM_WATCHDOG_EN to add the err output and WAIT timeout.
module mm_stream_host
  import mm_pkg::*;
#(
  parameter int L_RAM_SIZE = 3,
  parameter int BITWIDTH   = 32,
  parameter int WDT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  mm_axis_if.slave   s_axis,
  mm_axis_if.master  m_axis,
  mm_core_if.host    mm,
  output logic       busy
`ifdef MM_WATCHDOG_EN
  ,
  output logic       err
`endif
);

  localparam int AW = addr_w(L_RAM_SIZE);
  localparam int MS = mat_size(L_RAM_SIZE);

  state_e        state_q, state_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-2:0] drain_q, drain_d;

  logic          fire_s, fire_m;
  logic          wdt_hit;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [BITWIDTH-1:0] ram_wdata;

  assign fire_s = (state_q == S_FILL) && s_axis.tvalid;
  assign fire_m = (state_q == S_DRAIN) && m_axis.tready;

`ifdef MM_WATCHDOG_EN
  localparam int WdtW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  logic [WdtW-1:0] wdt_q, wdt_d;
  logic            err_q, err_d;

  assign wdt_hit = (state_q == S_WAIT)
                && (wdt_q == WdtW'(WDT_CYCLES - 1));
  assign wdt_d   = (state_q == S_WAIT) ? wdt_q + 1'b1 : '0;
  assign err_d   = wdt_hit && !mm.done;
  assign err     = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      err_q <= err_d;
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        if (fire_s) begin
          fill_d = fill_q + 1'b1;
          if (fill_q == AW'(2 * MS - 1))
            state_d = S_KICK;
        end
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        if (mm.done)      state_d = S_DRAIN;
        else if (wdt_hit) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (fire_m) begin
          drain_d = drain_q + 1'b1;
          if (drain_q == '1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
    end
  end

  // FILL and WAIT never overlap, so one write port is enough
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = fill_q;
    ram_wdata = s_axis.tdata;
    if (fire_s) begin
      ram_we = 1'b1;
    end else if (state_q == S_WAIT && mm.we) begin
      ram_we    = 1'b1;
      ram_waddr = mm.wraddr;
      ram_wdata = mm.wrdata;
    end
  end

  mm_op_ram #(
    .AW (AW),
    .DW (BITWIDTH)
  ) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .raddr_a_i (mm.rdaddr),
    .rdata_a_o (mm.rddata),
    .raddr_b_i ({1'b0, drain_q}),
    .rdata_b_o (m_axis.tdata)
  );

  assign s_axis.tready = (state_q == S_FILL);
  assign m_axis.tvalid = (state_q == S_DRAIN);
  assign m_axis.tlast  = (state_q == S_DRAIN) && (drain_q == '1);
  assign mm.start      = (state_q == S_KICK);
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mm_stream_host.sv
// Directed bench for mm_stream_host with a behavioural multiplier.
// Watchdog checks run when MM_WATCHDOG_EN is defined.
module tb_mm_stream_host;

  localparam int L  = 3;
  localparam int DW = 32;
  localparam int AW = 2 * L + 1;
  localparam int MS = 1 << (2 * L);
  localparam int VS = 1 << L;

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef MM_WATCHDOG_EN
  logic err;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] a_m [MS];
  logic [DW-1:0] b_m [MS];
  logic [DW-1:0] exp_m [MS];
  logic [DW-1:0] rd_m [2*MS];

  mm_axis_if #(.DW(DW)) s_if ();
  mm_axis_if #(.DW(DW)) m_if ();
  mm_core_if #(.AW(AW), .DW(DW)) c_if ();

  mm_stream_host #(
    .L_RAM_SIZE (L),
    .BITWIDTH   (DW),
    .WDT_CYCLES (100)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .s_axis (s_if),
    .m_axis (m_if),
    .mm     (c_if),
    .busy   (busy)
`ifdef MM_WATCHDOG_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int w);
    return (w < MS) ? a_m[w] : b_m[w-MS];
  endfunction

  // Streams words 0..stop_at-1; with stop_at=2*MS also checks the kick.
  task automatic fill(input int stop_at, input bit gaps, input bit hold129);
    int w = 0;
    int cyc = 0;
    while (w < stop_at && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (c_if.done) chk("fill_no_drain", m_if.tvalid, 0);
      if (gaps && (cyc % 3 == 0)) begin
        s_if.tvalid = 1'b0;
      end else begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = word(w);
      end
      if (s_if.tvalid && s_if.tready) w++;
    end
    chk("fill_words", w, stop_at);
    if (stop_at == 2 * MS) begin
      @(negedge clk);
      c_if.done = 1'b0;
      chk("kick_start", c_if.start, 1);
      chk("kick_tready", s_if.tready, 0);
      if (hold129) begin
        s_if.tdata = 32'hdead_beef;
        @(negedge clk);
        chk("w129_tready", s_if.tready, 0);
        chk("w129_busy", busy, 1);
      end
      s_if.tvalid = 1'b0;
    end
  endtask

  // Behavioural multiplier: snapshot operands, write C over A, then done.
  task automatic run_core();
    logic [DW-1:0] acc;
    @(negedge clk);
    chk("start_once", c_if.start, 0);
    for (int a = 0; a < 2 * MS; a++) begin
      @(negedge clk);
      c_if.rdaddr = AW'(a);
      #1;
      rd_m[a] = c_if.rddata;
    end
    for (int o = 0; o < MS; o++) begin
      acc = '0;
      for (int k = 0; k < VS; k++)
        acc += rd_m[(o / VS) * VS + k] * rd_m[MS + k * VS + (o % VS)];
      @(negedge clk);
      c_if.we     = 1'b1;
      c_if.wraddr = AW'(o);
      c_if.wrdata = acc;
    end
    @(negedge clk);
    c_if.we   = 1'b0;
    c_if.done = 1'b1;
  endtask

  task automatic drain(input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [DW-1:0] hd;
    while (idx < MS && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 3) c_if.done = 1'b0;
      if (cyc == 1) chk("done_to_valid", m_if.tvalid, 1);
      if (held) chk("hold_data", m_if.tdata, hd);
      m_if.tready = toggle ? (cyc % 2 == 1) : 1'b1;
      held = 1'b0;
      if (m_if.tvalid && m_if.tready) begin
        chk("out_data", m_if.tdata, exp_m[idx]);
        chk("out_last", m_if.tlast, (idx == MS - 1));
        idx++;
      end else if (m_if.tvalid) begin
        held = 1'b1;
        hd   = m_if.tdata;
      end
    end
    chk("drain_count", idx, MS);
    @(negedge clk);
    c_if.done = 1'b0;
    chk("post_valid", m_if.tvalid, 0);
    chk("post_idle", busy, 0);
  endtask

  task automatic load_job(input int kind);
    for (int i = 0; i < MS; i++) begin
      a_m[i] = (i / VS == i % VS) ? 32'd1 : 32'd0;
      unique case (kind)
        0: begin b_m[i] = i + 1;   exp_m[i] = i + 1;   end
        1: begin b_m[i] = 100 + i; exp_m[i] = 100 + i; end
        2: begin
          a_m[i]   = a_m[i] * 2;
          b_m[i]   = 3;
          exp_m[i] = 6;
        end
        default: begin b_m[i] = 2 * i; exp_m[i] = 2 * i; end
      endcase
    end
  endtask

  initial begin
    reset       = 1'b1;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    c_if.done   = 1'b0;
    c_if.rdaddr = '0;
    c_if.wraddr = '0;
    c_if.wrdata = '0;
    c_if.we     = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tready", s_if.tready, 0);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_start", c_if.start, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("fill_busy", busy, 1);
    chk("fill_tready", s_if.tready, 1);

    load_job(0);
    fill(2 * MS, 1'b0, 1'b0);
    run_core();
    drain(1'b0);

    fill(2 * MS, 1'b0, 1'b0);
    run_core();
    drain(1'b1);

    load_job(1);
    fill(2 * MS, 1'b1, 1'b1);
    run_core();
    drain(1'b0);

    load_job(2);
    fill(40, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    s_if.tvalid = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tready", s_if.tready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fill(2 * MS, 1'b0, 1'b0);
    run_core();
    drain(1'b0);

    load_job(3);
    c_if.done = 1'b1;
    fill(2 * MS, 1'b0, 1'b0);
    run_core();
    drain(1'b0);

`ifdef MM_WATCHDOG_EN
    fill(2 * MS, 1'b0, 1'b0);
    @(negedge clk);
    chk("wdt_k0", err, 0);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk("wdt_err", err, (k == 100));
      chk("wdt_valid", m_if.tvalid, 0);
      if (k == 100) chk("wdt_busy", busy, 0);
    end
    repeat (3) begin
      @(negedge clk);
      chk("wdt_err_off", err, 0);
      chk("wdt_no_valid", m_if.tvalid, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_stream_host.md
Name: mm_stream_host

Overview:
- Host-side counterpart of the matrix-multiplier core's RAM interface.
- Owns the 2^(2L+1)-word operand/result RAM and fills it from an input word stream (A then B, row-major).
- Pulses start to the multiplier, then services its combinational read port and its write port while it runs.
- After done, streams the MATRIX_SIZE result words back out; sits between a DMA/stream fabric and the multiplier core.

Parameters:
- L_RAM_SIZE, 3, log2 of matrix dimension; VECTOR_SIZE = 2^L, MATRIX_SIZE = 2^(2L).
- BITWIDTH, 32, data word width.
- WDT_CYCLES, 4096, watchdog limit in cycles; used only with MM_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_tdata  in  BITWIDTH  input operand word
- s_tvalid  in  1  input word valid
- s_tready  out  1  accepting input (FILL only)
- m_tdata  out  BITWIDTH  result word
- m_tvalid  out  1  result valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  marks result word MATRIX_SIZE-1
- mm_start  out  1  one-cycle start pulse to multiplier
- mm_done  in  1  multiplier done (held several cycles)
- mm_rdaddr  in  2L+1  multiplier read address
- mm_rddata  out  BITWIDTH  RAM[mm_rdaddr], combinational, zero latency
- mm_wraddr  in  2L+1  multiplier write address
- mm_wrdata  in  BITWIDTH  multiplier write data
- mm_we  in  1  multiplier write enable
- busy  out  1  high in every state except IDLE

Behaviour:
- RAM: 2*MATRIX_SIZE words. Async read on the mm port and on the drain port; single synchronous write port. Contents are not cleared by reset.
- States: IDLE, FILL, KICK, WAIT, DRAIN. Reset (asynchronous, any state, including mid-FILL or mid-DRAIN) forces IDLE, all counters 0, s_tready=0, m_tvalid=0, m_tlast=0, mm_start=0, busy=0.
- IDLE -> FILL unconditionally on the next cycle. IDLE exists only as a one-cycle post-reset/post-drain settle.
- FILL:
  - s_tready=1.
  - Each s_tvalid&&s_tready cycle writes s_tdata to RAM[fill_cnt] and increments fill_cnt.
  - Words 0..MATRIX_SIZE-1 are A; MATRIX_SIZE..2*MATRIX_SIZE-1 are B.
  - The handshake on word 2*MATRIX_SIZE-1 moves to KICK; s_tready drops the following cycle.
- KICK: mm_start=1 for exactly one cycle -> WAIT.
- WAIT:
  - The mm write port owns the RAM; mm_we writes mm_wrdata to RAM[mm_wraddr].
  - The first cycle with mm_done=1 moves to DRAIN. mm_done is ignored in every other state.
- mm_we outside WAIT is ignored. FILL writes and mm writes never coincide.
- DRAIN:
  - m_tvalid=1 and m_tdata=RAM[drain_cnt].
  - drain_cnt advances only on m_tvalid&&m_tready; m_tdata and m_tvalid are held stable under backpressure.
  - m_tlast=1 when drain_cnt==MATRIX_SIZE-1.
  - The handshake on that word moves to IDLE with m_tvalid=0 next cycle.
- Latency:
  - Last input handshake to mm_start: 1 cycle.
  - mm_done to first m_tvalid: 1 cycle.
  - Drain takes MATRIX_SIZE cycles at full m_tready. Drain exceeds the multiplier's done hold, so no re-start can overlap its done window.
- Counters:
  - fill_cnt is 2L+1 bits and wraps to 0 on leaving FILL.
  - drain_cnt is 2L bits and wraps to 0 on leaving DRAIN.
- s_tvalid outside FILL: the word is not consumed (s_tready=0) and not dropped.

Optional Feature:
- MM_WATCHDOG_EN defined:
  - Adds output err (1 bit, reset 0) and a cycle counter cleared on entering WAIT.
  - If WAIT lasts WDT_CYCLES cycles without mm_done: err pulses 1 cycle, the FSM goes to IDLE, and no results are streamed.
- Undefined: no err port; WAIT waits indefinitely.

Decomposition:
- Shared package mm_pkg: state encoding constants (S_IDLE..S_DRAIN), VECTOR_SIZE/MATRIX_SIZE derivation, address-width function 2L+1.
- One natural sub-module, mm_op_ram: 2*MATRIX_SIZE x BITWIDTH RAM with one sync write port and two async read ports.

Test Plan:
- L=3, stream 64-word identity A then B[i]=i+1, with the real multiplier attached -> mm_start pulses once 1 cycle after word 127; 64 outputs equal 1..64 in order; m_tlast on the 64th only.
- Same run, m_tready toggled 1-0-1 every cycle -> 64 outputs correct, no duplicates or skips; m_tdata held during each low cycle.
- s_tvalid gaps (every third cycle idle) during FILL -> still exactly 128 words accepted; s_tready=0 once KICK is reached; a 129th word stays unconsumed.
- Assert reset at input word 40, then replay a full job -> busy=0 during reset; the second job's results are correct (A=2I, B all 3 -> all outputs 6).
- mm_done forced high during FILL by bench stub -> no state change; the later real done triggers DRAIN normally.
- MM_WATCHDOG_EN, WDT_CYCLES=100, stub never asserts mm_done -> err=1 for one cycle exactly 100 cycles after entering WAIT, then busy drops and m_tvalid never rises.
